// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_responder
// Brief    : MEM-stage data-memory responder. Word-addressed store with a
//            fixed multi-cycle access latency and a ready/freeze handshake.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
  parameter int DEPTH     = 64,
  parameter int BASE_ADDR = 1024,
  parameter int LATENCY   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic [31:0] Address,
  input  logic [31:0] Wdata,
  output logic [31:0] Rdata,
  output logic        ready
);

  localparam int          c_aw   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          c_cw   = $clog2(LATENCY + 1);
  localparam logic [31:0] c_base = 32'(BASE_ADDR);
  localparam logic [c_cw-1:0] c_lat = c_cw'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [c_cw-1:0]   cnt_q, cnt_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       mem_q [DEPTH];

  logic              w_req;
  logic              w_store;
  logic [31:0]       w_offset;
  logic [c_aw-1:0]   w_idx;
  logic              w_unused_bits;

  // Request decode and word index; wrap modulo DEPTH falls out of truncation.
  assign w_req         = MEM_R_EN | MEM_W_EN;
  assign w_offset      = Address - c_base;
  assign w_idx         = w_offset[c_aw+1:2];
  assign w_unused_bits = ^{w_offset[31:c_aw+2], w_offset[1:0]};

  // Next-state logic: accept in IDLE, count in BUSY, commit on BUSY->DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    w_store = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          state_d = S_BUSY;
          cnt_d   = c_cw'(1);
        end
      end
      S_BUSY: begin
        if (cnt_q == c_lat) begin
          state_d = S_DONE;
          // A store wins when both enables are high; Rdata is then untouched.
          if (MEM_W_EN) begin
            w_store = 1'b1;
          end else if (MEM_R_EN) begin
            rdata_d = mem_q[w_idx];
          end
        end else begin
          cnt_d = cnt_q + c_cw'(1);
        end
      end
      S_DONE: begin
        // Never start a new access here; a held request restarts from IDLE.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state, latency counter and load result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
    end
  end

  // Data store: no reset; a reset mid-access forces IDLE so no commit occurs.
  always_ff @(posedge clk) begin
    if (w_store) begin
      mem_q[w_idx] <= Wdata;
    end
  end

  // Ready drops in the same cycle a request appears.
  assign ready = ((state_q == S_IDLE) && !w_req) || (state_q == S_DONE);
  assign Rdata = rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_responder
// Brief    : Self-checking bench for data_mem_responder; directed cases plus
//            randomized accesses against a word-array reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_responder;

  localparam int DEPTH = 64;
  localparam int BASE  = 1024;
  localparam int LAT   = 4;

  logic        clk;
  logic        rst;
  logic        MEM_R_EN;
  logic        MEM_W_EN;
  logic [31:0] Address;
  logic [31:0] Wdata;
  logic [31:0] Rdata;
  logic        ready;

  int n_tests;
  int n_fail;

  logic [31:0] model_mem [DEPTH];
  logic [31:0] exp_rdata;

  data_mem_responder #(
    .DEPTH    (DEPTH),
    .BASE_ADDR(BASE),
    .LATENCY  (LAT)
  ) u_dut (
    .clk     (clk),
    .rst     (rst),
    .MEM_R_EN(MEM_R_EN),
    .MEM_W_EN(MEM_W_EN),
    .Address (Address),
    .Wdata   (Wdata),
    .Rdata   (Rdata),
    .ready   (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] off;
    off = (a - 32'(BASE)) >> 2;
    return int'(off % 32'(DEPTH));
  endfunction

  // One full access starting in an IDLE cycle; returns #1 after the edge
  // leaving DONE, i.e. in the following IDLE cycle.
  task automatic do_access(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] d);
    MEM_R_EN = r;
    MEM_W_EN = w;
    Address  = a;
    Wdata    = d;
    for (int c = 0; c <= LAT + 1; c++) begin
      @(negedge clk);
      if (c <= LAT) begin
        check("ready_busy", {31'b0, ready}, 32'd0);
        check("rdata_hold", Rdata, exp_rdata);
      end else begin
        if (w) model_mem[word_of(a)] = d;
        else if (r) exp_rdata = model_mem[word_of(a)];
        check("ready_done", {31'b0, ready}, 32'd1);
        check("rdata_done", Rdata, exp_rdata);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle_cycle();
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    @(negedge clk);
    check("ready_idle", {31'b0, ready}, 32'd1);
    check("rdata_idle", Rdata, exp_rdata);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] a;
    logic        r;
    logic        w;
    n_tests  = 0;
    n_fail   = 0;
    rst      = 1'b0;
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b0;
    Address  = 32'd0;
    Wdata    = 32'd0;
    exp_rdata = 32'd0;

    // Asynchronous reset, observed before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_rdata", Rdata, 32'd0);
    check("rst_ready", {31'b0, ready}, 32'd1);
    #9 rst = 1'b0;
    @(posedge clk);
    #1;

    // Fill the whole store so every later load has a known value.
    for (int i = 0; i < DEPTH; i++) begin
      do_access(1'b0, 1'b1, 32'(BASE + 4 * i), $urandom);
    end
    idle_cycle();

    // Store then load the base word.
    do_access(1'b0, 1'b1, 32'd1024, 32'hDEADBEEF);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    check("base_load", Rdata, 32'hDEADBEEF);
    idle_cycle();

    // Wrap-around and ignored low address bits.
    do_access(1'b0, 1'b1, 32'd1028, 32'h11111111);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'(1028 + 4 * DEPTH), 32'h0);
    check("wrap_load", Rdata, 32'h11111111);
    do_access(1'b1, 1'b0, 32'd1030, 32'h0);
    check("lowbits_load", Rdata, 32'h11111111);
    idle_cycle();

    // Back-to-back load then store, request held across DONE.
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    do_access(1'b0, 1'b1, 32'd1024, 32'hCAFEF00D);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'd1024, 32'h0);
    check("b2b_store", Rdata, 32'hCAFEF00D);
    idle_cycle();

    // Reset during BUSY with cnt==2 aborts an uncommitted store.
    MEM_R_EN = 1'b0;
    MEM_W_EN = 1'b1;
    Address  = 32'd1032;
    Wdata    = 32'h5A5A5A5A;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_ready_req", {31'b0, ready}, 32'd0);
    check("midrst_rdata", Rdata, 32'd0);
    exp_rdata = 32'd0;
    MEM_W_EN = 1'b0;
    #1;
    check("midrst_ready_idle", {31'b0, ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_access(1'b1, 1'b0, 32'd1032, 32'h0);
    check("midrst_old_word", Rdata, model_mem[2]);
    idle_cycle();

    // Both enables high: acts as a store, Rdata held.
    do_access(1'b1, 1'b1, 32'd1036, 32'h12345678);
    idle_cycle();
    do_access(1'b1, 1'b0, 32'd1036, 32'h0);
    check("both_en_load", Rdata, 32'h12345678);
    idle_cycle();

    // Randomized mix of loads, stores, combined requests and gaps.
    for (int i = 0; i < 300; i++) begin
      r = 1'($urandom_range(0, 1));
      w = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else a = 32'(BASE) + 32'($urandom_range(0, 12 * DEPTH - 1));
      if (!r && !w) idle_cycle();
      else do_access(r, w, a, $urandom);
    end
    idle_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
